// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel valid/ready arbiter (round-robin or fixed) feeding a one-entry output register
module rr_mux_arb #(
   parameter int WIDTH = 32,
   parameter int N = 4,
   parameter int ARB_MODE = 1,
   localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_sel_q, out_sel_d, ptr_q, ptr_d, k;
   logic             out_valid_q, out_valid_d, found, load;
   logic [SELW:0]    idx;
   logic [N-1:0]     grant;
   // search from ptr upward with wrap; fixed mode keeps ptr at 0 so this yields the lowest index
   always_comb begin
      k = '0;
      found = 1'b0;
      idx = '0;
      for (int j = 0; j < N; j++) begin
         idx = {1'b0, ptr_q} + (SELW+1)'(j);
         idx = (idx >= (SELW+1)'(N)) ? idx - (SELW+1)'(N) : idx;
         if (!found && in_valid[idx[SELW-1:0]]) begin
            found = 1'b1;
            k = idx[SELW-1:0];
         end
      end
      grant = found ? N'(1) << k : '0;
      load = ~out_valid_q | out_ready;
      in_ready = (reset_n && load) ? grant : '0;
   end
   // output stage refills whenever it is empty or being consumed
   always_comb begin
      out_valid_d = load ? found : out_valid_q;
      out_data_d = (load && found) ? in_data[int'(k)*WIDTH +: WIDTH] : out_data_q;
      out_sel_d = (load && found) ? k : out_sel_q;
      ptr_d = (load && found && ARB_MODE != 0) ? ((k == SELW'(N-1)) ? '0 : k + SELW'(1)) : ptr_q;
   end
   // state registers with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q <= '0;
         out_sel_q <= '0;
         ptr_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q <= out_data_d;
         out_sel_q <= out_sel_d;
         ptr_q <= ptr_d;
      end
   end
   assign out_data = out_data_q;
   assign out_sel = out_sel_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed checks of round-robin and fixed-priority instances
module tb_rr_mux_arb;
   logic         clk, reset_n, out_ready;
   logic [127:0] in_data;
   logic [3:0]   in_valid, in_ready, f_in_ready;
   logic [31:0]  out_data, f_out_data;
   logic [1:0]   out_sel, f_out_sel;
   logic         out_valid, f_out_valid;
   int checks = 0;
   int errors = 0;
   rr_mux_arb #(.WIDTH(32), .N(4), .ARB_MODE(1)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready));
   rr_mux_arb #(.WIDTH(32), .N(4), .ARB_MODE(0)) dut_f (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(f_in_ready),
      .out_data(f_out_data), .out_sel(f_out_sel), .out_valid(f_out_valid), .out_ready(out_ready));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      reset_n = 1'b0;
      out_ready = 1'b0;
      in_valid = 4'b0000;
      in_data = '0;
      repeat (2) step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
      checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", out_sel); end
      in_valid = 4'b1111;
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
      in_valid = 4'b0000;
      reset_n = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL idle_data: got %h expected 0", out_data); end
   endtask
   task automatic test_single();
      in_data[64 +: 32] = 32'h1234abcd;
      in_valid = 4'b0100;
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready: got %b expected 0100", in_ready); end
      step();
      in_valid = 4'b0000;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== 32'h1234abcd) begin errors++; $display("FAIL single_data: got %h expected 1234abcd", out_data); end
      checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL single_sel: got %0d expected 2", out_sel); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
      checks++; if (out_data !== 32'h1234abcd) begin errors++; $display("FAIL single_hold: got %h expected 1234abcd", out_data); end
   endtask
   task automatic test_round_robin();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + i;
      in_valid = 4'b1111;
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready: got %b expected 0001", in_ready); end
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, out_valid); end
         checks++; if (out_sel !== 2'(i % 4)) begin errors++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", i, out_sel, i % 4); end
         checks++; if (out_data !== 32'hA0 + 32'(i % 4)) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, out_data, 32'hA0 + 32'(i % 4)); end
      end
   endtask
   task automatic test_backpressure();
      in_valid = 4'b0010;
      step();
      checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL bp_setup_sel: got %0d expected 1", out_sel); end
      in_valid = 4'b1111;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, in_ready); end
         step();
         checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 32'hA1) begin errors++; $display("FAIL bp_frozen[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=1 data=a1", i, out_valid, out_sel, out_data); end
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_resume_ready: got %b expected 0100", in_ready); end
      step();
      checks++; if (out_sel !== 2'd2 || out_data !== 32'hA2) begin errors++; $display("FAIL bp_resume: got sel=%0d data=%h expected sel=2 data=a2", out_sel, out_data); end
   endtask
   task automatic test_fixed();
      in_valid = 4'b1010;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (f_in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready[%0d]: got %b expected 0010", i, f_in_ready); end
         step();
         checks++; if (f_out_valid !== 1'b1 || f_out_sel !== 2'd1 || f_out_data !== 32'hA1) begin errors++; $display("FAIL fixed_out[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=1 data=a1", i, f_out_valid, f_out_sel, f_out_data); end
      end
   endtask
   task automatic test_async_reset();
      in_valid = 4'b1111;
      out_ready = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_stall_valid: got %b expected 1", out_valid); end
      #3;
      reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin errors++; $display("FAIL ar_cleared: got v=%b data=%h sel=%0d expected v=0 data=0 sel=0", out_valid, out_data, out_sel); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL ar_in_ready: got %b expected 0000", in_ready); end
      #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hA0) begin errors++; $display("FAIL ar_first_grant: got v=%b sel=%0d data=%h expected v=1 sel=0 data=a0", out_valid, out_sel, out_data); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_fixed();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
